// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU.
//   op_e      : opcode encoding (12..15 are undefined)
//   FLAG_*    : bit positions inside the 4-bit {N,Z,C,V} flags bus
//   state_e   : controller states of alu_pipe
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_EOR   = 4'd4,
    OP_BIC   = 4'd5,
    OP_RSB   = 4'd6,
    OP_CMPEQ = 4'd7,
    OP_LSL   = 4'd8,
    OP_LSR   = 4'd9,
    OP_ASR   = 4'd10,
    OP_MUL   = 4'd11
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Only instantiated when ALU_PIPE_MUL_EN is defined.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load operands and begin WIDTH iterations
//   a, b       : multiplicand / multiplier, sampled when start is high
//   done       : high once all iterations have finished (level, held until next start)
//   product    : full 2*WIDTH-bit product, valid while done is high
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;   // iterations remaining; terminal count is zero

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign done    = (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with valid/ready handshakes on both sides. All opcodes
// except MUL finish in one cycle; MUL (only when the macro ALU_PIPE_MUL_EN is
// defined) runs on the iterative multiplier and completes WIDTH+1 cycles after
// acceptance. Without the macro, opcode 11 is reported as illegal.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   in_valid, in_ready : request handshake; a, b, op captured on acceptance
//   a, b, op           : operands and 4-bit opcode
//   out_valid/out_ready: result handshake
//   result, flags      : registered result and {N,Z,C,V}
//   eq                 : CMPEQ outcome (0 for every other opcode)
//   illegal            : undefined opcode was issued
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | can accept a request when the output register is free
// ST_MUL_BUSY | multiplier iterating or waiting for the output register
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             eq,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] W_AMT = (WIDTH + 1)'(WIDTH);

  state_e state;
  logic   accept;
  logic   is_mul;
  logic   mul_start;
  logic   mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic   out_free;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  assign is_mul    = (op == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_start   = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Single-cycle datapath
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   asr_ext;
  logic             shift_zero;
  logic             shift_big;
  logic [WIDTH-1:0] res_c;
  logic [3:0]       flags_c;
  logic             c_c;
  logic             v_c;
  logic             eq_c;
  logic             ill_c;
  logic             arith_c;

  assign sum_ext    = {1'b0, a} + {1'b0, b};
  // One extra bit beside the operand catches the last bit shifted out.
  assign lsl_ext    = {1'b0, a} << b;
  assign lsr_ext    = {a, 1'b0} >> b;
  assign asr_ext    = $signed({a, 1'b0}) >>> b;
  assign shift_zero = (b == '0);
  assign shift_big  = ({1'b0, b} >= W_AMT);

  always_comb begin
    res_c   = '0;
    c_c     = 1'b0;
    v_c     = 1'b0;
    eq_c    = 1'b0;
    ill_c   = 1'b0;
    arith_c = 1'b1;
    case (op)
      OP_ADD: begin
        res_c = sum_ext[MSB:0];
        c_c   = sum_ext[WIDTH];
        v_c   = (a[MSB] == b[MSB]) && (res_c[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_c = a - b;
        c_c   = (a >= b);
        v_c   = (a[MSB] != b[MSB]) && (res_c[MSB] != a[MSB]);
      end
      OP_RSB: begin
        res_c = b - a;
        c_c   = (b >= a);
        v_c   = (b[MSB] != a[MSB]) && (res_c[MSB] != b[MSB]);
      end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_EOR: res_c = a ^ b;
      OP_BIC: res_c = a & ~b;
      OP_CMPEQ: begin
        eq_c    = (a == b);
        arith_c = 1'b0;
      end
      OP_LSL: begin
        if (shift_zero)     res_c = a;
        else if (shift_big) res_c = '0;
        else                {c_c, res_c} = lsl_ext;
      end
      OP_LSR: begin
        if (shift_zero)     res_c = a;
        else if (shift_big) res_c = '0;
        else                {res_c, c_c} = lsr_ext;
      end
      OP_ASR: begin
        if (shift_zero) begin
          res_c = a;
        end else if (shift_big) begin
          res_c = {WIDTH{a[MSB]}};
          c_c   = a[MSB];
        end else begin
          {res_c, c_c} = asr_ext;
        end
      end
      // MUL takes the multiplier path when enabled; otherwise it is illegal.
      default: begin
        ill_c   = 1'b1;
        arith_c = 1'b0;
      end
    endcase

    flags_c = '0;
    if (arith_c) begin
      flags_c[FLAG_N] = res_c[MSB];
      flags_c[FLAG_Z] = (res_c == '0);
      flags_c[FLAG_C] = c_c;
      flags_c[FLAG_V] = v_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      eq        <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && is_mul) begin
            state <= ST_MUL_BUSY;
            if (out_valid && out_ready) out_valid <= 1'b0;
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= res_c;
            flags     <= flags_c;
            eq        <= eq_c;
            illegal   <= ill_c;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done && out_free) begin
            state           <= ST_IDLE;
            out_valid       <= 1'b1;
            result          <= mul_product[MSB:0];
            flags[FLAG_N]   <= mul_product[MSB];
            flags[FLAG_Z]   <= (mul_product[MSB:0] == '0);
            flags[FLAG_C]   <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            flags[FLAG_V]   <= 1'b0;
            eq              <= 1'b0;
            illegal         <= 1'b0;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       eq;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .eq        (eq),
    .illegal   (illegal)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;   // {N,Z,C,V}
    logic       eq;
    logic       ill;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] r, input logic [3:0] f,
                           input logic e, input logic il);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " result"},    32'(result),    32'(r));
    chk({tag, " flags"},     32'(flags),     32'(f));
    chk({tag, " eq"},        32'(eq),        32'(e));
    chk({tag, " illegal"},   32'(illegal),   32'(il));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lowc;
    int seen;
    bit got;

    vecs[0]  = '{OP_ADD,   8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD,   8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,   8'h03, 8'h05, 8'hFE, 4'b1000, 1'b0, 1'b0};
    vecs[3]  = '{OP_RSB,   8'h03, 8'h05, 8'h02, 4'b0010, 1'b0, 1'b0};
    vecs[4]  = '{OP_CMPEQ, 8'h5A, 8'h5A, 8'h00, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{OP_CMPEQ, 8'h5A, 8'h5B, 8'h00, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{OP_ASR,   8'h80, 8'h03, 8'hF0, 4'b1000, 1'b0, 1'b0};
    vecs[7]  = '{OP_LSR,   8'h81, 8'h01, 8'h40, 4'b0010, 1'b0, 1'b0};
    vecs[8]  = '{OP_LSL,   8'h01, 8'h09, 8'h00, 4'b0100, 1'b0, 1'b0};
    vecs[9]  = '{4'd13,    8'h12, 8'h34, 8'h00, 4'b0000, 1'b0, 1'b1};
    vecs[10] = '{OP_AND,   8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{OP_OR,    8'hF0, 8'h0F, 8'hFF, 4'b1000, 1'b0, 1'b0};
    vecs[12] = '{OP_EOR,   8'hFF, 8'hFF, 8'h00, 4'b0100, 1'b0, 1'b0};
    vecs[13] = '{OP_BIC,   8'hFF, 8'h0F, 8'hF0, 4'b1000, 1'b0, 1'b0};
    vecs[14] = '{OP_LSL,   8'h81, 8'h01, 8'h02, 4'b0010, 1'b0, 1'b0};
    vecs[15] = '{OP_ASR,   8'h80, 8'h09, 8'hFF, 4'b1010, 1'b0, 1'b0};
    vecs[16] = '{OP_LSR,   8'h80, 8'h00, 8'h80, 4'b1000, 1'b0, 1'b0};
    vecs[17] = '{OP_SUB,   8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0, 1'b0};
    vecs[18] = '{4'd15,    8'hAA, 8'h55, 8'h00, 4'b0000, 1'b0, 1'b1};
    vecs[19] = '{OP_LSL,   8'h81, 8'h08, 8'h00, 4'b0100, 1'b0, 1'b0};
    vecs[20] = '{OP_ASR,   8'h40, 8'h08, 8'h00, 4'b0100, 1'b0, 1'b0};
    vecs[21] = '{OP_ADD,   8'h80, 8'h80, 8'h00, 4'b0111, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result",    32'(result),    32'd0);
    chk("rst flags",     32'(flags),     32'd0);
    chk("rst eq",        32'(eq),        32'd0);
    chk("rst illegal",   32'(illegal),   32'd0);

    // Vector table issued back to back: one result per cycle expected.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
      @(posedge clk); #1;
      check_out($sformatf("v%0d", i), vecs[i].res, vecs[i].flg, vecs[i].eq, vecs[i].ill);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // Four ADDs with a 3-cycle output stall after the second.
    @(negedge clk); op = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1; check_out("s1", 8'd2, 4'b0000, 1'b0, 1'b0);
    @(negedge clk); a = 8'd2; b = 8'd2;
    @(posedge clk); #1; check_out("s2", 8'd4, 4'b0000, 1'b0, 1'b0);
    @(negedge clk); a = 8'd3; b = 8'd3; out_ready = 1'b0; #1;
    chk("stall in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_out($sformatf("hold%0d", k), 8'd4, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; #1;
    chk("unstall in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1; check_out("s3", 8'd6, 4'b0000, 1'b0, 1'b0);
    @(negedge clk); a = 8'd4; b = 8'd4;
    @(posedge clk); #1; check_out("s4", 8'd8, 4'b0000, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("s end out_valid", 32'(out_valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
    // MUL latency and in_ready low time.
    @(negedge clk); op = OP_MUL; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0; lowc = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); in_valid = 1'b0;
      if (!in_ready) lowc++;
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        lat = k + 1;
        break;
      end
    end
    chk("mul got result", 32'(got), 32'd1);
    chk("mul latency", 32'(lat), 32'd9);
    chk("mul ready low", 32'(lowc), 32'd9);
    check_out("mul1", 8'h00, 4'b0110, 1'b0, 1'b0);

    // MUL completing into a stalled consumer holds its result.
    @(negedge clk); op = OP_MUL; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1; check_out("mul2", 8'hFF, 4'b1000, 1'b0, 1'b0);
    chk("mul2 in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1; check_out("mul2 hold", 8'hFF, 4'b1000, 1'b0, 1'b0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mul2 consumed", 32'(out_valid), 32'd0);

    // Reset on the fourth cycle of a MUL aborts it.
    @(negedge clk); op = OP_MUL; a = 8'h03; b = 8'h05; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
`else
    // Opcode 11 is illegal without the multiplier.
    @(negedge clk); op = OP_MUL; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    check_out("mul ill", 8'h00, 4'b0000, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("mul ill in_ready", 32'(in_ready), 32'd1);

    // Reset while an unconsumed result is held.
    op = OP_ADD; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
`endif
    @(posedge clk);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("aborted no result", 32'(seen), 32'd0);
    chk("post-rst result", 32'(result), 32'd0);
    @(negedge clk); op = OP_ADD; a = 8'd2; b = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    check_out("post-rst add", 8'h05, 4'b0000, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 The block SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  in  1  operation request; in_ready  out  1  block can accept a request.
REQ-005 a, b  in  WIDTH  operands; op  in  4  opcode.
REQ-006 out_valid  out  1  result valid; out_ready  in  1  consumer accepts result.
REQ-007 result  out  WIDTH  registered result; flags  out  4  {N,Z,C,V}; eq  out  1  A==B from CMPEQ; illegal  out  1  undefined opcode.
REQ-008 The block SHALL use a single clock, clk; reset is synchronous and active-high.

Function
REQ-009 Opcodes SHALL be: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 EOR, 5 BIC (a&~b), 6 RSB (b-a), 7 CMPEQ, 8 LSL, 9 LSR, 10 ASR, 11 MUL; 12..15 illegal.
REQ-010 A request is accepted on a cycle with in_valid && in_ready; operands and op are captured on that edge and need not be held.
REQ-011 in_ready SHALL be 1 only when state==IDLE and (!out_valid || out_ready).
REQ-012 Every opcode except MUL has latency 1: out_valid rises on the edge after acceptance.
REQ-013 Back-to-back single-cycle operations SHALL sustain one result per cycle while out_ready=1.
REQ-014 While out_valid && !out_ready, result, flags, eq and illegal SHALL hold stable and no new request is accepted.
REQ-015 Output registers SHALL update only on acceptance completion; a result is consumed on out_valid && out_ready, clearing out_valid unless a new result completes on the same edge.
REQ-016 ADD/SUB/RSB: result is modulo 2^WIDTH; C = carry-out (ADD) or no-borrow (SUB: a>=b unsigned; RSB: b>=a); V = two's-complement signed overflow.
REQ-017 AND/OR/EOR/BIC: C=0, V=0.
REQ-018 N = result[WIDTH-1]; Z = (result==0) for all legal opcodes.
REQ-019 CMPEQ: eq=(a==b), result=0, flags=0; eq SHALL be 0 for every other opcode (always registered, never latched).
REQ-020 Shifts use unsigned amount b; amount 0: result=a, C=0; amount>=WIDTH: LSL/LSR result 0, ASR result all copies of a[WIDTH-1], C = 0 for LSL/LSR and a[WIDTH-1] for ASR; otherwise C = last bit shifted out; V=0.
REQ-021 Illegal opcode: result=0, flags=0, eq=0, illegal=1, latency 1; illegal=0 for every legal opcode.
REQ-022 State machine SHALL have states IDLE, MUL_BUSY; IDLE->MUL_BUSY on accepted MUL; MUL_BUSY->IDLE after WIDTH iteration cycles, asserting out_valid on the transition edge.
REQ-023 MUL: unsigned shift-add, latency WIDTH+1 cycles from acceptance; result = low WIDTH bits of product; C = (high half != 0); V=0.
REQ-024 in_ready SHALL be 0 throughout MUL_BUSY; out_valid of a prior result may still be consumed during MUL_BUSY.
REQ-025 MUL SHALL not complete while out_valid && !out_ready; the final iteration stalls in MUL_BUSY until the output register is free.

Reset
REQ-026 On reset: state=IDLE, out_valid=0, result=0, flags=0, eq=0, illegal=0, multiplier registers cleared; in_ready=1 on the first cycle after reset deassertion.
REQ-027 Reset asserted mid-MUL SHALL abort the operation; no result is ever produced for it.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN: when defined, MUL behaves per REQ-022..025.
REQ-029 Without ALU_PIPE_MUL_EN, opcode 11 SHALL be treated as illegal (REQ-021), MUL_BUSY is unreachable and no multiplier logic is instantiated.

Structure
REQ-030 Package alu_pipe_pkg SHALL hold the opcode enum, the flag bit index constants (N=3, Z=2, C=1, V=0) and the state enum.
REQ-031 The iterative multiplier SHALL be sub-module alu_mul_seq (start, operands in; done, product out), instantiated only under ALU_PIPE_MUL_EN.

Verification (WIDTH=8 unless stated)
REQ-032 ADD a=0xFF b=0x01, out_ready=1 -> next cycle result=0x00, flags N0 Z1 C1 V0; ADD 0x7F+0x01 -> 0x80, N1 V1 C0.
REQ-033 SUB a=0x03 b=0x05 -> 0xFE, N1 C0; RSB same operands -> 0x02, C1; CMPEQ 0x5A,0x5A -> eq=1, result 0.
REQ-034 ASR a=0x80 b=3 -> 0xF0, C0; LSR a=0x81 b=1 -> 0x40, C1; LSL a=0x01 b=9 -> 0x00, Z1; op=13 -> illegal=1.
REQ-035 MUL 0x10*0x20 (macro defined) -> in_ready low 9 cycles, result 0x00, C1, Z1; rerun undefined macro -> illegal=1 after 1 cycle.
REQ-036 Stream 4 ADDs with out_ready low 3 cycles mid-stream -> no lost/duplicated results, outputs stable while stalled, in_ready low during stall.
REQ-037 Assert reset at cycle 4 of a MUL -> out_valid stays 0, in_ready=1 after reset, next ADD 2+3 -> 0x05.
